// File: rtl/morpho_ctrl.sv
// morpho_ctrl: frame-synchronous controller for the 3x3 morphological filter
// chain. Tracks line/frame geometry, flags context-window border pixels,
// checks line lengths, counts frames and holds configuration in shadow
// registers that are committed atomically at frame start.
module morpho_ctrl #(
  parameter int LINE_LENGTH = 800,
  parameter int CTX_SIZE    = 3,
  parameter int CNT_W       = 11
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iLineValid,
  input  logic             iFrameValid,
  input  logic             iCfgValid,
  output logic             oCfgReady,
  input  logic [1:0]       iCfgAddr,
  input  logic [7:0]       iCfgData,
  output logic [2:0]       oMode,
  output logic [7:0]       oThreshold,
  output logic             oEnable,
  output logic             oPending,
  output logic             oBorder,
  output logic [CNT_W-1:0] oColCnt,
  output logic [CNT_W-1:0] oRowCnt,
  output logic             oLineErr,
  output logic [7:0]       oFrameCnt
);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_LINE   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LINE_LENGTH);
  localparam logic [CNT_W-1:0] EDGE_C   = CNT_W'(CTX_SIZE - 1);

  // Saturating increment so a runaway line cannot wrap the index back to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic [1:0]       state_r, state_n;
  logic             lv_r, fv_r;
  logic [CNT_W-1:0] col_r, col_n, row_r, row_n;
  logic [7:0]       frame_r, frame_n;
  logic             line_err_r, border_r, pending_r;
  logic [2:0]       mode_r, sh_mode_r;
  logic [7:0]       thr_r, sh_thr_r;
  logic             en_r, sh_en_r;

  logic             fr_s, ff_s, lr_s, lf_s;
  logic             commit_s, xfer_s, clr_err_s;
  logic             line_end_s, len_bad_s, pix_s, border_n;
  logic [CNT_W-1:0] cur_row_s;

  assign fr_s = iFrameValid & ~fv_r;
  assign ff_s = ~iFrameValid & fv_r;
  assign lr_s = iLineValid & ~lv_r;
  assign lf_s = ~iLineValid & lv_r;

  // The commit cycle is the only cycle that refuses a config write, so the
  // shadow registers are never written and copied on the same edge.
  assign commit_s  = (state_r == ST_VBLANK) & fr_s;
  assign oCfgReady = ~commit_s;
  assign xfer_s    = iCfgValid & oCfgReady;
  assign clr_err_s = xfer_s & (iCfgAddr == 2'd3);

  assign len_bad_s = line_end_s & (col_r != LEN_C);

  // A pixel is presented whenever both qualifiers are high after sync is found.
  assign pix_s     = iFrameValid & iLineValid & (state_r != ST_SYNC);
  // The row register still holds last frame's count in VBLANK; the first
  // pixel of a frame is always row 0.
  assign cur_row_s = (state_r == ST_VBLANK) ? CNT_ZERO : row_r;
  assign border_n  = pix_s & ((col_r < EDGE_C) | (cur_row_s < EDGE_C));

  // Geometry FSM: next state, column/row indices and frame count.
  always_comb begin
    state_n    = state_r;
    col_n      = col_r;
    row_n      = row_r;
    frame_n    = frame_r;
    line_end_s = 1'b0;
    case (state_r)
      ST_SYNC: begin
        col_n = CNT_ZERO;
        row_n = CNT_ZERO;
        if (!iFrameValid) begin
          state_n = ST_VBLANK;
        end else begin
          state_n = ST_SYNC;
        end
      end
      ST_VBLANK: begin
        if (fr_s) begin
          row_n = CNT_ZERO;
          if (iLineValid) begin
            col_n   = CNT_ONE;
            state_n = ST_LINE;
          end else begin
            col_n   = CNT_ZERO;
            state_n = ST_HBLANK;
          end
        end else begin
          state_n = ST_VBLANK;
        end
      end
      ST_HBLANK: begin
        if (ff_s) begin
          frame_n = frame_r + 8'd1;
          state_n = ST_VBLANK;
        end else if (lr_s) begin
          col_n   = sat_inc(col_r);
          state_n = ST_LINE;
        end else begin
          state_n = ST_HBLANK;
        end
      end
      ST_LINE: begin
        if (ff_s || lf_s) begin
          line_end_s = 1'b1;
          col_n      = CNT_ZERO;
          row_n      = sat_inc(row_r);
          if (ff_s) begin
            frame_n = frame_r + 8'd1;
            state_n = ST_VBLANK;
          end else begin
            state_n = ST_HBLANK;
          end
        end else begin
          col_n   = sat_inc(col_r);
          state_n = ST_LINE;
        end
      end
      default: begin
        col_n   = CNT_ZERO;
        row_n   = CNT_ZERO;
        state_n = ST_SYNC;
      end
    endcase
  end

  // Geometry registers: qualifier history, FSM state, counters, border flag.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r  <= ST_SYNC;
      lv_r     <= 1'b0;
      fv_r     <= 1'b0;
      col_r    <= CNT_ZERO;
      row_r    <= CNT_ZERO;
      frame_r  <= 8'd0;
      border_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      lv_r     <= iLineValid;
      fv_r     <= iFrameValid;
      col_r    <= col_n;
      row_r    <= row_n;
      frame_r  <= frame_n;
      border_r <= border_n;
    end
  end

  // Sticky line-length error; a detection beats a same-cycle clear.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      line_err_r <= 1'b0;
    end else if (len_bad_s) begin
      line_err_r <= 1'b1;
    end else if (clr_err_s) begin
      line_err_r <= 1'b0;
    end
  end

  // Shadow writes and atomic shadow-to-active commit at frame start.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sh_mode_r <= 3'd0;
      sh_thr_r  <= 8'd0;
      sh_en_r   <= 1'b0;
      mode_r    <= 3'd0;
      thr_r     <= 8'd0;
      en_r      <= 1'b0;
      pending_r <= 1'b0;
    end else if (commit_s) begin
      mode_r    <= sh_mode_r;
      thr_r     <= sh_thr_r;
      en_r      <= sh_en_r;
      pending_r <= 1'b0;
    end else if (xfer_s) begin
      case (iCfgAddr)
        2'd0: begin
          // Undefined mode codes are swallowed without touching the shadow.
          if (iCfgData[2:0] <= 3'd4) begin
            sh_mode_r <= iCfgData[2:0];
            pending_r <= 1'b1;
          end
        end
        2'd1: begin
          sh_thr_r  <= iCfgData;
          pending_r <= 1'b1;
        end
        2'd2: begin
          sh_en_r   <= iCfgData[0];
          pending_r <= 1'b1;
        end
        default: begin
          // Address 3 only clears the line error, handled above.
        end
      endcase
    end
  end

  assign oMode      = mode_r;
  assign oThreshold = thr_r;
  assign oEnable    = en_r;
  assign oPending   = pending_r;
  assign oBorder    = border_r;
  assign oColCnt    = col_r;
  assign oRowCnt    = row_r;
  assign oLineErr   = line_err_r;
  assign oFrameCnt  = frame_r;

endmodule

// File: tb/tb_morpho_ctrl.sv
// Directed bench for morpho_ctrl: reset sync, geometry, border, line error,
// configuration shadow/commit handshake.
module tb_morpho_ctrl;

  localparam int CNT_W = 11;

  logic             iClk = 1'b0;
  logic             iRst_n;
  logic             iLineValid, iFrameValid, iCfgValid;
  logic             oCfgReady;
  logic [1:0]       iCfgAddr;
  logic [7:0]       iCfgData;
  logic [2:0]       oMode;
  logic [7:0]       oThreshold;
  logic             oEnable, oPending, oBorder, oLineErr;
  logic [CNT_W-1:0] oColCnt, oRowCnt;
  logic [7:0]       oFrameCnt;

  int n_cmp = 0;
  int n_bad = 0;

  morpho_ctrl #(.LINE_LENGTH(800), .CTX_SIZE(3), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .iCfgValid(iCfgValid), .oCfgReady(oCfgReady), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData),
    .oMode(oMode), .oThreshold(oThreshold), .oEnable(oEnable), .oPending(oPending),
    .oBorder(oBorder), .oColCnt(oColCnt), .oRowCnt(oRowCnt), .oLineErr(oLineErr),
    .oFrameCnt(oFrameCnt)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    iCfgValid = 1'b1;
    iCfgAddr  = a;
    iCfgData  = d;
    tick();
    iCfgValid = 1'b0;
  endtask

  task automatic hblank(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("border_blank", 32'(oBorder), 32'd0);
    end
  endtask

  // One active line; optionally issues an error-clear write in the fall cycle.
  task automatic do_line(input int row, input int len, input bit clr_at_end);
    for (int i = 0; i < len; i++) begin
      iLineValid = 1'b1;
      chk("col", 32'(oColCnt), 32'(i));
      chk("row", 32'(oRowCnt), 32'(row));
      tick();
      chk("border", 32'(oBorder), ((i < 2) || (row < 2)) ? 32'd1 : 32'd0);
    end
    iLineValid = 1'b0;
    if (clr_at_end) begin
      iCfgValid = 1'b1;
      iCfgAddr  = 2'd3;
      iCfgData  = 8'd0;
    end
    tick();
    iCfgValid = 1'b0;
    chk("border_lf", 32'(oBorder), 32'd0);
    chk("col_end", 32'(oColCnt), 32'd0);
    chk("row_end", 32'(oRowCnt), 32'(row + 1));
  endtask

  initial begin
    iRst_n      = 1'b0;
    iFrameValid = 1'b1;
    iLineValid  = 1'b1;
    iCfgValid   = 1'b0;
    iCfgAddr    = 2'd0;
    iCfgData    = 8'd0;

    // Reset in the middle of an active line.
    tick(); tick(); tick();
    chk("rst_mode", 32'(oMode), 32'd0);
    chk("rst_thr", 32'(oThreshold), 32'd0);
    chk("rst_en", 32'(oEnable), 32'd0);
    chk("rst_pend", 32'(oPending), 32'd0);
    chk("rst_border", 32'(oBorder), 32'd0);
    chk("rst_col", 32'(oColCnt), 32'd0);
    chk("rst_row", 32'(oRowCnt), 32'd0);
    chk("rst_err", 32'(oLineErr), 32'd0);
    chk("rst_frame", 32'(oFrameCnt), 32'd0);
    chk("rst_ready", 32'(oCfgReady), 32'd1);
    iRst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("sync_col", 32'(oColCnt), 32'd0);
      chk("sync_row", 32'(oRowCnt), 32'd0);
      chk("sync_border", 32'(oBorder), 32'd0);
    end
    iFrameValid = 1'b0;
    iLineValid  = 1'b0;
    tick(); tick();
    chk("sync_frame", 32'(oFrameCnt), 32'd0);

    // Frame A: four 800-pixel lines, config writes between lines.
    iFrameValid = 1'b1;
    tick();
    chk("a_pend", 32'(oPending), 32'd0);
    hblank(20);
    do_line(0, 800, 1'b0);
    hblank(20);
    cfg_write(2'd0, 8'd6);
    chk("bad_mode_pend", 32'(oPending), 32'd0);
    cfg_write(2'd0, 8'd1);
    chk("wr_pend", 32'(oPending), 32'd1);
    cfg_write(2'd1, 8'd128);
    cfg_write(2'd2, 8'd1);
    chk("wr_mode_hold", 32'(oMode), 32'd0);
    chk("wr_thr_hold", 32'(oThreshold), 32'd0);
    chk("wr_en_hold", 32'(oEnable), 32'd0);
    do_line(1, 800, 1'b0);
    hblank(20);
    do_line(2, 800, 1'b0);
    hblank(20);
    do_line(3, 800, 1'b0);
    hblank(20);
    chk("a_err", 32'(oLineErr), 32'd0);
    iFrameValid = 1'b0;
    tick();
    chk("a_frames", 32'(oFrameCnt), 32'd1);
    tick(); tick();

    // Frame B: commit with a write held across the commit cycle.
    iFrameValid = 1'b1;
    iCfgValid   = 1'b1;
    iCfgAddr    = 2'd1;
    iCfgData    = 8'h55;
    #1;
    chk("ready_commit", 32'(oCfgReady), 32'd0);
    tick();
    chk("b_mode", 32'(oMode), 32'd1);
    chk("b_thr", 32'(oThreshold), 32'd128);
    chk("b_en", 32'(oEnable), 32'd1);
    chk("b_pend_clr", 32'(oPending), 32'd0);
    chk("b_row_clr", 32'(oRowCnt), 32'd0);
    chk("ready_after", 32'(oCfgReady), 32'd1);
    tick();
    iCfgValid = 1'b0;
    chk("held_wr_pend", 32'(oPending), 32'd1);
    chk("held_thr_hold", 32'(oThreshold), 32'd128);
    cfg_write(2'd0, 8'd7);
    hblank(5);
    do_line(0, 799, 1'b0);
    chk("short_err", 32'(oLineErr), 32'd1);
    cfg_write(2'd3, 8'd0);
    chk("err_clr", 32'(oLineErr), 32'd0);
    hblank(3);
    do_line(1, 799, 1'b1);
    chk("err_set_wins", 32'(oLineErr), 32'd1);
    hblank(3);
    iFrameValid = 1'b0;
    tick();
    chk("b_frames", 32'(oFrameCnt), 32'd2);
    tick(); tick();

    // Frame C: commit keeps mode 1 (bad write dropped), picks up threshold.
    iFrameValid = 1'b1;
    tick();
    chk("c_mode", 32'(oMode), 32'd1);
    chk("c_thr", 32'(oThreshold), 32'h55);
    chk("c_en", 32'(oEnable), 32'd1);
    chk("c_pend", 32'(oPending), 32'd0);
    hblank(2);
    iFrameValid = 1'b0;
    tick();
    chk("c_frames", 32'(oFrameCnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/morpho_ctrl.md
Name: morpho_ctrl

Overview:
- Frame-synchronous controller for the morphological filter chain (erosion/dilation, 3x3 context, 800-pixel lines).
- Tracks stream geometry from iLineValid/iFrameValid and accepts configuration writes into shadow registers.
- Commits the configuration atomically at frame start, so the datapath never changes mode mid-frame.
- Outputs the border-valid flag for the context window, line-length error detection and a frame counter.

Parameters:
LINE_LENGTH, 800, expected active pixels per line
CTX_SIZE, 3, context window edge size; sets the border region
CNT_W, 11, width of the column and row counters

Ports:
iClk  input  1  pixel clock
iRst_n  input  1  asynchronous active-low reset
iLineValid  input  1  active-pixel qualifier from the camera stream
iFrameValid  input  1  frame qualifier from the camera stream
iCfgValid  input  1  configuration write request
oCfgReady  output  1  configuration write accept
iCfgAddr  input  2  0=mode, 1=threshold, 2=enable, 3=clear error
iCfgData  input  8  write data
oMode  output  3  active mode: 0 bypass, 1 erode, 2 dilate, 3 open, 4 close
oThreshold  output  8  active binarisation threshold
oEnable  output  1  active filter enable
oPending  output  1  shadow differs from active (write accepted since last commit)
oBorder  output  1  current window touches outside-image pixels
oColCnt  output  CNT_W  column index of current input pixel
oRowCnt  output  CNT_W  row index of current input line
oLineErr  output  1  sticky: a line length differed from LINE_LENGTH
oFrameCnt  output  8  completed frames, wraps 255->0

Behaviour:
- Single clock domain: iClk.
- Reset: iRst_n is asynchronous and active-low.
- Reset values: all outputs 0 except oCfgReady=1. Shadow registers are also 0. State=SYNC.
- Edge detect: iLineValid and iFrameValid are registered once. Rise/fall events are computed from current vs registered values.
- SYNC: counters held at 0; waits until iFrameValid=0 is observed, then goes to VBLANK. This prevents counting a partial frame after a mid-frame reset.
- VBLANK:
  - On iFrameValid rise (FR): go to HBLANK, or to LINE if iLineValid=1 in the same cycle.
  - Also on FR: commit shadow->active, clear oPending, clear oRowCnt and oColCnt.
- LINE (iFrameValid=1, iLineValid=1):
  - oColCnt increments each cycle, saturating at 2^CNT_W-1.
  - On iLineValid fall: if the count != LINE_LENGTH, set oLineErr. Then clear oColCnt, increment oRowCnt and go to HBLANK.
- HBLANK: iLineValid rise -> LINE.
- Frame end: iFrameValid fall in LINE or HBLANK -> VBLANK, oFrameCnt+1. If the line was still active at that point, run the line-end check first.
- oColCnt/oRowCnt give the index of the pixel presented this cycle (pre-increment value).
- oBorder: registered, 1-cycle latency. Value is LINE & (oColCnt < CTX_SIZE-1 | oRowCnt < CTX_SIZE-1). With CTX_SIZE=3, columns 0,1 and rows 0,1 are flagged.
- Config handshake:
  - A transfer occurs when iCfgValid & oCfgReady.
  - oCfgReady=0 only in the single cycle in which a commit occurs, so a write never collides with a commit.
  - A requester holding iCfgValid completes on the next cycle.
- Config writes:
  - addr0: shadow mode <= iCfgData[2:0]. Values 5-7 are dropped; the transfer still completes and oPending is unchanged.
  - addr1: shadow threshold. addr2: shadow enable <= iCfgData[0]. Each accepted addr0-2 write sets oPending.
  - addr3: clears oLineErr immediately, no shadow effect. If a line-length error is detected in the same cycle, set wins.
- Multiple writes before a commit: last value wins per register.
- Active outputs change only at commit, visible the cycle after FR.

Test Plan:
- Reset mid-frame (FV=1, LV=1 at col 300), release -> counters stay 0 until FV low then high; outputs at reset values, oCfgReady=1.
- 4 lines of 800 pixels, 20-cycle hblank, 1 frame -> oRowCnt 0..3, oColCnt 0..799 per line, oLineErr=0, oFrameCnt=1.
- Line of 799 pixels -> oLineErr=1 after LV fall; write addr3 -> 0 next cycle; short line with addr3 write in same cycle -> stays 1.
- Write mode=1, thr=128, en=1 during frame -> oPending=1, oMode unchanged; next FR -> oMode=1, oThreshold=128, oEnable=1, oPending=0. Write held during FR -> accepted one cycle later, oPending=1.
- Write mode=6 -> transfer completes, shadow and oPending unchanged, next commit keeps old mode.
- oBorder at rows 0-1 or cols 0-1 = 1; pixel (row2,col2) -> 0, each delayed 1 cycle; 0 in blanking.
